// File: rtl/expr_pkg.sv
// Shared definitions for the streaming expression evaluator: ASCII codes,
// token-class encoding and a digit classifier.
package expr_pkg;

    localparam logic [7:0] ChZero = 8'h30;
    localparam logic [7:0] ChNine = 8'h39;
    localparam logic [7:0] ChPlus = 8'h2b;
    localparam logic [7:0] ChStar = 8'h2a;
    localparam logic [7:0] ChLpar = 8'h28;
    localparam logic [7:0] ChRpar = 8'h29;

    // Class of the most recently accepted token.
    typedef enum logic [1:0] {
        LastNone = 2'd0,
        LastOpnd = 2'd1,
        LastOp   = 2'd2,
        LastLpar = 2'd3
    } last_e;

    function automatic logic is_digit(logic [7:0] c);
        return (c >= ChZero) && (c <= ChNine);
    endfunction

endpackage

// File: rtl/expr_eval_if.sv
// Character-stream interface of expr_eval: one ASCII char in, registered
// value/done/err out.
interface expr_eval_if #(
    parameter int unsigned W = 32
);
    logic [7:0]   in;
    logic [W-1:0] value;
    logic         done;
    logic         err;

    modport master (output in, input value, done, err);
    modport slave  (input in, output value, done, err);
endinterface

// File: rtl/expr_stack.sv
// LIFO of {S,P} pairs for enclosing nesting levels. Top is combinational so a
// ')' can fold the popped level in the same cycle.
module expr_stack #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  logic [2*W-1:0] wdata,
    output logic [2*W-1:0] top,
    output logic           full,
    output logic           empty
);
    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]  ptr_q;
    logic [2*W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr) begin
            ptr_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PW'(1);
        end else if (pop) begin
            ptr_q <= ptr_q - PW'(1);
        end
    end

    // Entry storage needs no reset: only slots below the pointer are ever read.
    always_ff @(posedge clk) begin
        if (clr && push) begin
            mem_q[AW'(ptr_q)] <= wdata;
        end
    end

    always_comb begin
        full  = (ptr_q == PW'(DEPTH));
        empty = (ptr_q == '0);
        top   = empty ? '0 : mem_q[AW'(ptr_q - PW'(1))];
    end

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit +, * and parenthesised expressions,
// one char per clock, reporting the value of every complete prefix.
module expr_eval
    import expr_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           clr,
    expr_eval_if.slave     bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic [W-1:0]   s_q, s_d, p_q, p_d, value_q, value_d, sum, digit_val;
    logic [DW-1:0]  depth_q, depth_d;
    last_e          last_q, last_d;
    logic           err_q, err_d, done_q, done_d;
    logic           push, pop, ok, full, empty;
    logic [2*W-1:0] top;

    expr_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata ({s_q, p_q}),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!clr) begin
            s_q     <= '0;
            p_q     <= W'(1);
            depth_q <= '0;
            last_q  <= LastNone;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
        end else begin
            s_q     <= s_d;
            p_q     <= p_d;
            depth_q <= depth_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        s_d       = s_q;
        p_d       = p_q;
        depth_d   = depth_q;
        last_d    = last_q;
        err_d     = err_q;
        done_d    = done_q;
        value_d   = value_q;
        push      = 1'b0;
        pop       = 1'b0;
        ok        = 1'b1;
        sum       = s_q + p_q;
        digit_val = W'(bus.in[3:0]);

        // After an error everything holds until clr.
        if (!err_q) begin
            if (is_digit(bus.in)) begin
                ok     = (last_q != LastOpnd);
                p_d    = p_q * digit_val;
                last_d = LastOpnd;
            end else if (bus.in == ChStar) begin
                ok     = (last_q == LastOpnd);
                last_d = LastOp;
            end else if (bus.in == ChPlus) begin
                ok     = (last_q == LastOpnd);
                s_d    = sum;
                p_d    = W'(1);
                last_d = LastOp;
            end else if (bus.in == ChLpar) begin
                ok      = (last_q != LastOpnd) && !full;
                push    = ok;
                s_d     = '0;
                p_d     = W'(1);
                depth_d = depth_q + DW'(1);
                last_d  = LastLpar;
            end else if (bus.in == ChRpar) begin
                ok      = (last_q == LastOpnd) && !empty;
                pop     = ok;
                s_d     = top[2*W-1:W];
                p_d     = top[W-1:0] * sum;
                depth_d = depth_q - DW'(1);
                last_d  = LastOpnd;
            end else begin
                ok = 1'b0;
            end

            if (!ok) begin
                s_d     = s_q;
                p_d     = p_q;
                depth_d = depth_q;
                last_d  = last_q;
                err_d   = 1'b1;
                done_d  = 1'b0;
            end else begin
                done_d = (last_d == LastOpnd) && (depth_d == '0);
                if (done_d) begin
                    value_d = s_d + p_d;
                end
            end
        end
    end

    always_comb begin
        bus.value = value_q;
        bus.done  = done_q;
        bus.err   = err_q;
    end

endmodule

// File: tb/tb_expr_eval.sv
// Scoreboard bench for expr_eval: a W=32 and a W=8 instance share one char
// stream; a grammar-level model with a shunting-yard evaluator predicts outputs.
module tb_expr_eval;

    localparam int unsigned DEPTH = 8;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [31:0] value;
    } exp_t;

    logic clk;
    logic clr;

    expr_eval_if #(.W(32)) bus32 ();
    expr_eval_if #(.W(8))  bus8 ();

    expr_eval #(.W(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .clr(clr), .bus(bus32));
    expr_eval #(.W(8),  .DEPTH(DEPTH)) dut8  (.clk(clk), .clr(clr), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    // Model state: the accepted prefix since the last clear.
    byte unsigned pre[$];
    int           m_depth;
    bit           m_err;
    bit           m_done;
    logic [31:0]  m_value;

    logic [31:0]  vals[$];
    byte unsigned ops[$];

    function automatic bit is_dig(byte unsigned c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit after_opnd();
        if (pre.size() == 0) return 1'b0;
        return is_dig(pre[$]) || (pre[$] == ")");
    endfunction

    function automatic void reduce_top();
        logic [31:0]  a, b;
        byte unsigned op;
        b  = vals.pop_back();
        a  = vals.pop_back();
        op = ops.pop_back();
        if (op == "*") vals.push_back(a * b);
        else           vals.push_back(a + b);
    endfunction

    // Classic operator-precedence evaluation of the whole accepted prefix.
    function automatic logic [31:0] eval_prefix();
        vals.delete();
        ops.delete();
        foreach (pre[i]) begin
            byte unsigned c;
            c = pre[i];
            if (is_dig(c)) begin
                vals.push_back(32'(c - 8'h30));
            end else if (c == "(") begin
                ops.push_back(c);
            end else if (c == ")") begin
                while (ops[$] != "(") reduce_top();
                void'(ops.pop_back());
            end else if (c == "*") begin
                while (ops.size() > 0 && ops[$] == "*") reduce_top();
                ops.push_back(c);
            end else begin
                while (ops.size() > 0 && ops[$] != "(") reduce_top();
                ops.push_back(c);
            end
        end
        while (ops.size() > 0) reduce_top();
        return vals[0];
    endfunction

    function automatic void model_step(bit clr_v, byte unsigned c);
        bit ok;
        if (!clr_v) begin
            pre.delete();
            m_depth = 0;
            m_err   = 1'b0;
            m_done  = 1'b0;
            m_value = '0;
        end else if (!m_err) begin
            if (is_dig(c))                 ok = !after_opnd();
            else if (c == "+" || c == "*") ok = after_opnd();
            else if (c == "(")             ok = !after_opnd() && (m_depth < DEPTH);
            else if (c == ")")             ok = after_opnd() && (m_depth > 0);
            else                           ok = 1'b0;
            if (!ok) begin
                m_err  = 1'b1;
                m_done = 1'b0;
            end else begin
                pre.push_back(c);
                if (c == "(") m_depth++;
                if (c == ")") m_depth--;
                m_done = (is_dig(c) || c == ")") && (m_depth == 0);
                if (m_done) m_value = eval_prefix();
            end
        end
        sb_q.push_back('{done: m_done, err: m_err, value: m_value});
    endfunction

    task automatic step(bit clr_v, byte unsigned c);
        @(negedge clk);
        clr      = clr_v;
        bus32.in = c;
        bus8.in  = c;
        model_step(clr_v, c);
    endtask

    task automatic run_str(string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    endtask

    task automatic do_clr();
        step(1'b0, "1");
    endtask

    function automatic byte unsigned pick_char();
        int r;
        string any;
        any = "0123456789+*()";
        r = $urandom_range(0, 99);
        if (r < 2) return 8'h61;
        if (r < 6) return any[$urandom_range(0, 13)];
        if (after_opnd()) begin
            r = $urandom_range(0, 9);
            if (r < 4) return "+";
            if (r < 7) return "*";
            return (m_depth > 0) ? ")" : "+";
        end
        if ($urandom_range(0, 3) == 0) return "(";
        return 8'(8'h30 + $urandom_range(0, 9));
    endfunction

    // Monitor: one expectation per clock edge, checked just after the edge.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                bad = 1'b0;
                n_vec++;
                if (bus32.done !== e.done) begin
                    $display("FAIL done vec %0d: got %b want %b", n_vec, bus32.done, e.done);
                    bad = 1'b1;
                end
                if (bus32.err !== e.err) begin
                    $display("FAIL err vec %0d: got %b want %b", n_vec, bus32.err, e.err);
                    bad = 1'b1;
                end
                if (bus32.value !== e.value) begin
                    $display("FAIL value32 vec %0d: got %0d want %0d", n_vec, bus32.value,
                             e.value);
                    bad = 1'b1;
                end
                if (bus8.done !== e.done || bus8.err !== e.err) begin
                    $display("FAIL flags8 vec %0d: got done=%b err=%b want done=%b err=%b",
                             n_vec, bus8.done, bus8.err, e.done, e.err);
                    bad = 1'b1;
                end
                if (bus8.value !== e.value[7:0]) begin
                    $display("FAIL value8 vec %0d: got %0d want %0d", n_vec, bus8.value,
                             e.value[7:0]);
                    bad = 1'b1;
                end
                if (bad) n_miss++;
            end
        end
    end

    initial begin
        clr      = 1'b0;
        bus32.in = 8'h00;
        bus8.in  = 8'h00;
        do_clr();
        do_clr();
        run_str("(1+2)*(3+1)+1+2");
        do_clr();
        run_str("2+3*4");
        do_clr();
        run_str("2+3+4(+1)5");
        do_clr();
        run_str("1+");
        step(1'b0, "1");
        run_str("+(9)");
        do_clr();
        run_str("1+(9)");
        do_clr();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, "(");
        step(1'b1, "1");
        do_clr();
        run_str(")");
        do_clr();
        run_str("9*9*9*9");
        do_clr();
        run_str("(((7)))");
        do_clr();
        run_str("((((((((1+2)*3))))))))*5+x");
        do_clr();
        for (int i = 0; i < 4000; i++) begin
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0) begin
                do_clr();
            end else begin
                step(1'b1, pick_char());
            end
        end
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming evaluator for single-digit arithmetic expressions over `+`, `*` and parentheses, one ASCII character per clock. It sits directly downstream of the expression-syntax checker and consumes the same character stream. It tracks operator precedence and nesting with an internal operand stack. After every character it reports whether the prefix so far is a complete expression, and if so its value modulo 2^W.

## Interface
- `W`, 32: value/accumulator width; all arithmetic is mod 2^W.
- `DEPTH`, 8: maximum parenthesis nesting depth (stack entries).

- `clk`  in  1  single clock, all state on rising edge.
- `clr`  in  1  synchronous, active-low clear.
- `in`  in  8  ASCII character, sampled every rising edge (no valid strobe; one char per cycle).
- `value`  out  W  result of the last complete prefix.
- `done`  out  1  prefix including last sampled char is a complete, well-formed expression.
- `err`  out  1  sticky syntax/capacity error.

## Operation
- Legal chars: `'0'..'9'`, `'+'`, `'*'`, `'('`, `')'`. Any other char sets err.
- Per-level registers: sum S and product P. Level 0 starts at S=0, P=1.
- Stack holds the {S,P} pairs of the enclosing levels; depth counter runs 0..DEPTH.
- Token state `last` ∈ {NONE, OPND, OP, LPAR}. Reset value is NONE.
- digit d: requires last ∈ {NONE, OP, LPAR}. Action: P ← P·d, last ← OPND.
- `'*'`: requires last=OPND. Action: last ← OP (P retained).
- `'+'`: requires last=OPND. Action: S ← S+P, P ← 1, last ← OP.
- `'('`: requires last ∈ {NONE, OP, LPAR} and depth<DEPTH. Action: push {S,P}, S ← 0, P ← 1, depth+1, last ← LPAR.
- `')'`: requires last=OPND and depth>0. Action: f = S+P, pop {S',P'}, S ← S', P ← P'·f, depth−1, last ← OPND.
- Any violated requirement sets err. Once err=1, all state is frozen and further chars are ignored until clr.
- done = (last=OPND) & (depth=0) & !err.
- When done would be 1, value ← S+P using the post-update S and P. Otherwise value holds its previous value.
- Multiply and add truncate to W bits. There is no overflow flag.

## Timing
- All outputs are registered. The char sampled at edge k is reflected in done/value/err immediately after edge k (1-cycle latency, full throughput).
- Reset values: value=0, done=0, err=0, depth=0, S=0, P=1, last=NONE.
- clr low at an edge takes priority: the char on `in` at that edge is discarded. The first char evaluated is the one at the first edge with clr high.
- Reset mid-expression at any depth fully discards stack contents. No stale entries are visible afterwards.
- `')'` needs the pop result in the same cycle: the stack top is readable combinationally. The write/pointer update happens at the edge.
- `'('` at depth=DEPTH sets err. `')'` at depth=0 sets err. Neither modifies the stack.

## Structure
- Package `expr_pkg`: ASCII char constants, the `last` token-class encoding, and an `is_digit` helper.
- Sub-module `expr_stack` (params W, DEPTH): synchronous-reset LIFO of 2W-bit entries. It has push/pop inputs, a combinational top output, and full/empty outputs. Push and pop are never asserted together.
- Top `expr_eval`: decode, token-class FSM, S/P datapath, error logic.

## Test plan
- "(1+2)*(3+1)+1+2": done=1/value=12 after second `')'`. After the following `'+'`: done=0, value=12. After `'1'`: value=13. After final `'2'`: value=15.
- "2+3*4": value goes 2 → (hold) → 5 → (hold) → 14. Confirms precedence.
- "2+3+4(": err=1 on the edge after `'('`, done=0, value stays 9. Further chars change nothing.
- Mid-stream clr low for one edge with in=`'1'`, then "+(9)" → err=1 (leading `'+'`). Separately, clr edge then "1+(9)" → value=10 after `')'`.
- DEPTH+1 consecutive `'('` → err on the last one. Fresh start with ")" → err=1 immediately.
- W=8: "9*9*9*9" → value=161 (6561 mod 256). "(((7)))" → value=7, done only after third `')'`.
